// File: rtl/lsu_controller.sv
// lsu_controller: sized load/store sequencer for a byte-addressed 64-bit DataMemory.
// Optional macro MISALIGN_TRAP_EN: accesses with addr not a multiple of the size fault.
module lsu_controller #(
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [63:0] PARK_ADDR = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] Read_Data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [2:0]  r_f3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_fault;
    logic [63:0] r_rdata;
    logic [63:0] r_old;

    logic        w_acc;
    logic [3:0]  w_n_in;
    logic [64:0] w_end;
    logic        w_range_bad;
    logic        w_misalign;
    logic        w_fault_in;
    logic [63:0] w_load_ext;
    logic [63:0] w_mask;
    logic [63:0] w_merged;

    assign w_acc       = req_valid & req_ready;
    assign w_n_in      = 4'd1 << req_funct3[1:0];
    assign w_end       = {1'b0, req_addr} + {61'd0, w_n_in};
    assign w_range_bad = w_end > 65'(MEM_BYTES);

`ifdef MISALIGN_TRAP_EN
    logic [2:0] w_lowmask;
    assign w_lowmask  = 3'(w_n_in - 4'd1);
    assign w_misalign = |(req_addr[2:0] & w_lowmask);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault_in = (req_funct3 == 3'b111)
                      | (req_write & req_funct3[2])
                      | w_range_bad
                      | w_misalign;

    // extend the low N bytes of the memory word for a load
    always_comb begin
        w_load_ext = '0;
        unique case (r_f3[1:0])
            2'b00: w_load_ext = r_f3[2] ? {56'd0, Read_Data[7:0]}
                                        : {{56{Read_Data[7]}}, Read_Data[7:0]};
            2'b01: w_load_ext = r_f3[2] ? {48'd0, Read_Data[15:0]}
                                        : {{48{Read_Data[15]}}, Read_Data[15:0]};
            2'b10: w_load_ext = r_f3[2] ? {32'd0, Read_Data[31:0]}
                                        : {{32{Read_Data[31]}}, Read_Data[31:0]};
            2'b11: w_load_ext = Read_Data;
        endcase
    end

    // byte-lane mask of the store target; a D store replaces all eight bytes
    always_comb begin
        w_mask = '0;
        unique case (r_f3[1:0])
            2'b00: w_mask = 64'h0000_0000_0000_00FF;
            2'b01: w_mask = 64'h0000_0000_0000_FFFF;
            2'b10: w_mask = 64'h0000_0000_FFFF_FFFF;
            2'b11: w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign w_merged = (r_old & ~w_mask) | (r_wdata & w_mask);

    // next-state sequencing
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_acc) begin
                    if (w_fault_in) begin
                        w_next = RESP;
                    end else if (req_write && req_funct3[1:0] == 2'b11) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:   w_next = r_write ? WR : RESP;
            WR:   w_next = RESP;
            RESP: w_next = IDLE;
        endcase
    end

    // state register, request capture and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
            r_rdata <= '0;
            r_old   <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_write <= req_write;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_fault <= w_fault_in;
                r_rdata <= '0;
            end
            if (r_state == RD) begin
                if (r_write) begin
                    r_old <= Read_Data;
                end else begin
                    r_rdata <= w_load_ext;
                end
            end
        end
    end

    // core-side and memory-side outputs decoded from the registered state
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_fault = 1'b0;
        Mem_Addr   = PARK_ADDR;
        Write_Data = '0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        unique case (r_state)
            IDLE: req_ready = 1'b1;
            RD: begin
                Mem_Addr = r_addr;
                MemRead  = 1'b1;
            end
            WR: begin
                Mem_Addr   = r_addr;
                Write_Data = w_merged;
                MemWrite   = 1'b1;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_fault = r_fault;
            end
        endcase
    end

endmodule
